// File: rtl/musa_pkg.sv
// Shared MUSA core definitions: flag codes, default widths, exception decode.
package musa_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 3;
  localparam int RA_W   = 5;

  typedef enum logic [FLAG_W-1:0] {
    FLAG_NOT_ACTIVED = 3'b000,
    FLAG_EQUAL       = 3'b001,
    FLAG_EXCEPTION   = 3'b010,
    FLAG_OVERFLOW    = 3'b011,
    FLAG_UNDERFLOW   = 3'b100,
    FLAG_ABOVE       = 3'b101
  } flag_e;

  // A flag-writing instruction that reports EXCEPTION is a divide fault.
  function automatic logic is_exception(input logic we, input logic [FLAG_W-1:0] flag);
    return we && (flag == FLAG_EXCEPTION);
  endfunction

endpackage

// File: rtl/flag_reg_unit.sv
// Architectural flag register; its output also feeds the ALU BRFL compare.
module flag_reg_unit
  import musa_pkg::*;
#(
  parameter int W = FLAG_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         stall_i,
  input  logic         we_i,
  input  logic [W-1:0] flag_i,
  output logic [W-1:0] flag_o
);

  logic [W-1:0] flag_q;

  // Write only on an unstalled flag-writing instruction; reset to NOT_ACTIVED.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 flag_q <= '0;
    else if (!stall_i && we_i)   flag_q <= flag_i;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU outputs and MEM controls, issues
// one-cycle redirect and exception pulses, supports stall and flush.
module ex_mem_reg #(
  parameter int DATA_W = musa_pkg::DATA_W,
  parameter int FLAG_W = musa_pkg::FLAG_W,
  parameter int RA_W   = musa_pkg::RA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flag,
  input  logic              alu_branch,
  input  logic              flag_we,
  input  logic [RA_W-1:0]   rd_addr,
  input  logic              rd_we,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] store_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [RA_W-1:0]   out_rd_addr,
  output logic              out_rd_we,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [DATA_W-1:0] out_store_data,
  output logic [FLAG_W-1:0] flag_reg,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              exc
);
  import musa_pkg::*;

  logic              valid_q, rd_we_q, mem_rd_q, mem_wr_q, redirect_q, exc_q;
  logic [DATA_W-1:0] result_q, store_data_q, redirect_pc_q;
  logic [RA_W-1:0]   rd_addr_q;

  // Next-state controls for an accepted instruction; a fault squashes its
  // side effects (writeback, memory access, branch) but not the flag write.
  logic take, exc_d, rd_we_d, mem_rd_d, mem_wr_d, redirect_d;
  assign take       = in_valid && !flush;
  assign exc_d      = is_exception(flag_we, alu_flag);
  assign rd_we_d    = rd_we      && !exc_d;
  assign mem_rd_d   = mem_rd     && !exc_d;
  assign mem_wr_d   = mem_wr     && !exc_d;
  assign redirect_d = alu_branch && !exc_d;

  // Stall holds state but drops the pulses; flush/bubble clears controls only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q       <= 1'b0;
      rd_we_q       <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      redirect_q    <= 1'b0;
      exc_q         <= 1'b0;
      result_q      <= '0;
      store_data_q  <= '0;
      redirect_pc_q <= '0;
      rd_addr_q     <= '0;
    end else if (stall) begin
      redirect_q    <= 1'b0;
      exc_q         <= 1'b0;
    end else if (take) begin
      valid_q       <= 1'b1;
      rd_we_q       <= rd_we_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      redirect_q    <= redirect_d;
      exc_q         <= exc_d;
      result_q      <= alu_result;
      store_data_q  <= store_data;
      redirect_pc_q <= alu_result;
      rd_addr_q     <= rd_addr;
    end else begin
      valid_q       <= 1'b0;
      rd_we_q       <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      redirect_q    <= 1'b0;
      exc_q         <= 1'b0;
    end
  end

  flag_reg_unit #(.W(FLAG_W)) u_flag (
    .clk_i   (clock),
    .rst_ni  (reset),
    .stall_i (stall),
    .we_i    (take && flag_we),
    .flag_i  (alu_flag),
    .flag_o  (flag_reg)
  );

  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_rd_addr    = rd_addr_q;
  assign out_rd_we      = rd_we_q;
  assign out_mem_rd     = mem_rd_q;
  assign out_mem_wr     = mem_wr_q;
  assign out_store_data = store_data_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign exc            = exc_q;

endmodule
